// File: rtl/pipe_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// pipe_hazard_scoreboard
//
// Hazard and forwarding controller for the in-order pipeline. It sits at the
// ID/EX boundary and keeps a shift-register scoreboard of in-flight register
// writers. Entry 0 is the instruction in EX and entry DEPTH-1 is the one in WB.
// Each cycle it decides whether the instruction in ID must stall, and which
// pipeline stage (if any) feeds each source operand through the forwarding
// muxes.
//
// Parameters
//   AW        register index width
//   DEPTH     number of tracked stages after ID (legal 2..8)
//   LOAD_RDY  first entry index at which a load result can be forwarded
//   CNT_W     stall counter width
//   SW        forwarding-select width, derived from DEPTH
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   id_valid     ID holds a real instruction (not a bubble)
//   id_rs1       ID source 1 index
//   id_rs2       ID source 2 index
//   id_use_rs2   ID instruction reads rs2
//   id_rd        ID destination index
//   id_regwrite  ID instruction writes rd
//   id_is_load   ID instruction is a load
//   flush        taken branch: the ID instruction is killed this cycle
//   ex_hold      EX busy with a multicycle op: the tracked pipe is frozen
//   stall        hold PC and IF/ID, insert a bubble into ID/EX
//   fwd_a        rs1 source: 0 = register file, k = result held in entry k-1
//   fwd_b        rs2 source, same encoding
//   stall_cnt    saturating count of stall cycles since reset
// -----------------------------------------------------------------------------
module pipe_hazard_scoreboard #(
  parameter int AW       = 5,
  parameter int DEPTH    = 3,
  parameter int LOAD_RDY = 2,
  parameter int CNT_W    = 16,
  localparam int SW      = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [AW-1:0]    id_rs1,
  input  logic [AW-1:0]    id_rs2,
  input  logic             id_use_rs2,
  input  logic [AW-1:0]    id_rd,
  input  logic             id_regwrite,
  input  logic             id_is_load,
  input  logic             flush,
  input  logic             ex_hold,
  output logic             stall,
  output logic [SW-1:0]    fwd_a,
  output logic [SW-1:0]    fwd_b,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] rd;
    logic          is_load;
  } entry_t;

  entry_t ent [DEPTH];

  // Per-operand lookup results.
  logic          hit_a, hit_b;
  logic          haz_a, haz_b;
  logic [SW-1:0] sel_a, sel_b;
  logic          stall_raw;
  logic          issue;

  // Scan from the oldest entry to the youngest so the youngest matching
  // writer overwrites any older one (older writers are shadowed).
  always_comb begin
    // NOTE: every variable gets a default before the loop; otherwise a path
    // that leaves it unassigned would infer a latch.
    hit_a = 1'b0;
    haz_a = 1'b0;
    sel_a = '0;
    hit_b = 1'b0;
    haz_b = 1'b0;
    sel_b = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (ent[k].valid && (ent[k].rd == id_rs1) && (id_rs1 != '0)) begin
        hit_a = 1'b1;
        sel_a = SW'(k + 1);
        haz_a = ent[k].is_load && (k < LOAD_RDY);
      end
      if (id_use_rs2 && ent[k].valid && (ent[k].rd == id_rs2) && (id_rs2 != '0)) begin
        hit_b = 1'b1;
        sel_b = SW'(k + 1);
        haz_b = ent[k].is_load && (k < LOAD_RDY);
      end
    end
  end

  // A killed instruction never needs to wait, even for a busy EX stage.
  assign stall_raw = id_valid & (haz_a | haz_b | ex_hold) & ~flush;
  assign stall     = stall_raw & ~rst;

  // A select is only meaningful when the operand can actually be forwarded
  // this cycle; while stalled (for any reason) both selects read as 0.
  assign fwd_a = (~rst & hit_a & ~haz_a & ~stall_raw) ? sel_a : '0;
  assign fwd_b = (~rst & hit_b & ~haz_b & ~stall_raw) ? sel_b : '0;

  // x0 writers are never tracked: x0 is always read from the register file.
  assign issue = id_valid & id_regwrite & (id_rd != '0) & ~stall & ~flush;

  // NOTE: sequential state uses non-blocking assignments so the shift reads
  // every entry's pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: only the valid bits are cleared; rd and is_load are ignored
      // whenever valid is 0, so they need no reset value.
      for (int k = 0; k < DEPTH; k++) begin
        ent[k].valid <= 1'b0;
      end
    end else if (!ex_hold) begin
      ent[0] <= '{valid: issue, rd: id_rd, is_load: id_is_load};
      for (int k = 1; k < DEPTH; k++) begin
        ent[k] <= ent[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_scoreboard
//
// Drives two scoreboards from one input stream: u0 with the default parameters
// and u1 with DEPTH=4, LOAD_RDY=1, CNT_W=3. A behavioural model, holding the
// in-flight writers as a queue (youngest first), predicts every output of both
// instances each cycle. Directed steps cover the forwarding, load-use, x0,
// shadowing, flush, freeze, saturation and mid-stream reset cases; a random
// phase follows.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs2, id_regwrite, id_is_load;
  logic        flush, ex_hold;

  logic        stall0, stall1;
  logic [1:0]  fa0, fb0;
  logic [2:0]  fa1, fb1;
  logic [15:0] cnt0;
  logic [2:0]  cnt1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard u0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .flush(flush), .ex_hold(ex_hold),
    .stall(stall0), .fwd_a(fa0), .fwd_b(fb0), .stall_cnt(cnt0)
  );

  pipe_hazard_scoreboard #(.DEPTH(4), .LOAD_RDY(1), .CNT_W(3)) u1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_regwrite(id_regwrite),
    .id_is_load(id_is_load), .flush(flush), .ex_hold(ex_hold),
    .stall(stall1), .fwd_a(fa1), .fwd_b(fb1), .stall_cnt(cnt1)
  );

  // ---------------------------------------------------------------------------
  // Reference model: a queue of in-flight writers, youngest first.
  // ---------------------------------------------------------------------------
  typedef struct {
    bit v;
    int rd;
    bit ld;
  } mrec_t;
  typedef mrec_t mq_t[$];
  typedef struct {
    bit stall;
    int fa;
    int fb;
  } mout_t;

  mq_t   q0, q1;
  int    mc0 = 0, mc1 = 0;
  mout_t o0, o1;

  // Position of the youngest valid writer of r, or -1.
  function automatic int youngest(input mq_t q, input int r);
    int k = -1;
    if (r != 0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].v && q[i].rd == r) k = i;
      end
    end
    return k;
  endfunction

  function automatic mout_t predict(input mq_t q, input int lr);
    mout_t o;
    int    ka = youngest(q, int'(id_rs1));
    int    kb = id_use_rs2 ? youngest(q, int'(id_rs2)) : -1;
    bit    ha = (ka >= 0) && q[ka].ld && (ka < lr);
    bit    hb = (kb >= 0) && q[kb].ld && (kb < lr);
    o.stall = !rst && id_valid && (ha || hb || ex_hold) && !flush;
    o.fa    = (!rst && ka >= 0 && !ha && !o.stall) ? ka + 1 : 0;
    o.fb    = (!rst && kb >= 0 && !hb && !o.stall) ? kb + 1 : 0;
    return o;
  endfunction

  function automatic mq_t advance(input mq_t q, input int depth, input bit st);
    mq_t   n = q;
    mrec_t r;
    if (rst) begin
      n.delete();
    end else if (!ex_hold) begin
      r.v  = id_valid && id_regwrite && (id_rd != 0) && !st && !flush;
      r.rd = int'(id_rd);
      r.ld = id_is_load;
      n.push_front(r);
      if (n.size() > depth) void'(n.pop_back());
    end
    return n;
  endfunction

  function automatic int count(input int c, input int w, input bit st);
    if (rst) return 0;
    if (st && c < (1 << w) - 1) return c + 1;
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // Checking and stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then compare all outputs.
  task automatic apply(input bit r, input bit v, input int rs1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit fl, input bit hd);
    @(negedge clk);
    rst         = r;
    id_valid    = v;
    id_rs1      = rs1[4:0];
    id_rs2      = rs2[4:0];
    id_use_rs2  = u2;
    id_rd       = rd[4:0];
    id_regwrite = rw;
    id_is_load  = ld;
    flush       = fl;
    ex_hold     = hd;
    #1;
    o0 = predict(q0, 2);
    o1 = predict(q1, 1);
    cmp("u0.stall", {31'b0, stall0}, {31'b0, o0.stall});
    cmp("u0.fwd_a", {30'b0, fa0}, o0.fa);
    cmp("u0.fwd_b", {30'b0, fb0}, o0.fb);
    cmp("u0.stall_cnt", {16'b0, cnt0}, mc0);
    cmp("u1.stall", {31'b0, stall1}, {31'b0, o1.stall});
    cmp("u1.fwd_a", {29'b0, fa1}, o1.fa);
    cmp("u1.fwd_b", {29'b0, fb1}, o1.fb);
    cmp("u1.stall_cnt", {29'b0, cnt1}, mc1);
  endtask

  // Commit the model's next state and let the DUTs take the same edge.
  task automatic tick();
    q0  = advance(q0, 3, o0.stall);
    q1  = advance(q1, 4, o1.stall);
    mc0 = count(mc0, 16, o0.stall);
    mc1 = count(mc1, 3, o1.stall);
    @(posedge clk);
  endtask

  // Instruction forms used by the directed steps.
  task automatic bubble();
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) bubble();
  endtask

  int base;

  initial begin
    rst = 1'b1; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rd = '0;
    id_use_rs2 = 1'b0; id_regwrite = 1'b0; id_is_load = 1'b0;
    flush = 1'b0; ex_hold = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state, with a busy EX and a hazard-looking ID to show rst masks them.
    apply(1, 1, 5, 5, 1, 6, 1, 0, 0, 1);
    cmp("rst.stall", {31'b0, stall0}, 0);
    cmp("rst.cnt", {16'b0, cnt0}, 0);
    tick();
    bubble();

    // T1: add x5 ; sub x6,x5,x7 ; two more readers of x5 at increasing distance.
    apply(0, 1, 1, 2, 1, 5, 1, 0, 0, 0); tick();
    apply(0, 1, 5, 7, 1, 6, 1, 0, 0, 0);
    cmp("t1.fwd_a_ex", {30'b0, fa0}, 1);
    cmp("t1.stall", {31'b0, stall0}, 0);
    tick();
    apply(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    cmp("t1.fwd_a_mem", {30'b0, fa0}, 2);
    tick();
    apply(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    cmp("t1.fwd_a_wb", {30'b0, fa0}, 3);
    tick();
    drain();

    // T2: lw x5 ; add x6,x5,x5. u0 waits until the load reaches WB;
    // u1 (LOAD_RDY=1) waits one cycle and then forwards from entry 1.
    base = mc0;
    apply(0, 1, 1, 0, 0, 5, 1, 1, 0, 0); tick();
    apply(0, 1, 5, 5, 1, 6, 1, 0, 0, 0);
    cmp("t2.stall", {31'b0, stall0}, 1);
    cmp("t2.u1_stall", {31'b0, stall1}, 1);
    tick();
    apply(0, 1, 5, 5, 1, 6, 1, 0, 0, 0);
    cmp("t2.cnt_step", {16'b0, cnt0}, base + 1);
    cmp("t2.u1_fwd_a", {29'b0, fa1}, 2);
    tick();
    apply(0, 1, 5, 5, 1, 6, 1, 0, 0, 0);
    cmp("t2.fwd_a", {30'b0, fa0}, 3);
    cmp("t2.fwd_b", {30'b0, fb0}, 3);
    tick();
    drain();

    // T3: x0 writer is never tracked; back-to-back writers of x9 -> youngest wins.
    apply(0, 1, 1, 0, 0, 0, 1, 0, 0, 0); tick();
    apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("t3.x0", {30'b0, fa0}, 0);
    tick();
    apply(0, 1, 1, 0, 0, 9, 1, 0, 0, 0); tick();
    apply(0, 1, 2, 0, 0, 9, 1, 0, 0, 0); tick();
    apply(0, 1, 9, 9, 1, 0, 0, 0, 0, 0);
    cmp("t3.shadow_a", {30'b0, fa0}, 1);
    cmp("t3.shadow_b", {30'b0, fb0}, 1);
    tick();
    drain();

    // T4: lw x5 ; reader of x5 killed by flush (no stall, bubble inserted).
    apply(0, 1, 1, 0, 0, 5, 1, 1, 0, 0); tick();
    apply(0, 1, 5, 0, 0, 6, 1, 0, 1, 0);
    cmp("t4.flush_stall", {31'b0, stall0}, 0);
    tick();
    apply(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    cmp("t4.mem_load_stall", {31'b0, stall0}, 1);
    tick();
    apply(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    cmp("t4.fwd_a", {30'b0, fa0}, 3);
    cmp("t4.no_stall", {31'b0, stall0}, 0);
    tick();
    drain();

    // T5: add x5 ; four frozen cycles with a reader waiting in ID.
    base = mc0;
    apply(0, 1, 1, 0, 0, 5, 1, 0, 0, 0); tick();
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 5, 0, 0, 0, 0, 0, 0, 1);
      cmp("t5.hold_stall", {31'b0, stall0}, 1);
      tick();
    end
    apply(0, 1, 5, 0, 0, 0, 0, 0, 0, 0);
    cmp("t5.cnt", {16'b0, cnt0}, base + 4);
    cmp("t5.frozen_fwd", {30'b0, fa0}, 1);
    tick();
    // flush together with ex_hold: no stall.
    apply(0, 1, 5, 0, 0, 0, 0, 0, 1, 1);
    cmp("t5.flush_hold", {31'b0, stall0}, 0);
    tick();
    drain();

    // T6: saturate the 3-bit counter, then reset with three live writers.
    for (int i = 0; i < 10; i++) begin
      apply(0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
      tick();
    end
    apply(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    cmp("t6.saturate", {29'b0, cnt1}, 7);
    tick();
    apply(0, 1, 0, 0, 0, 1, 1, 0, 0, 0); tick();
    apply(0, 1, 0, 0, 0, 2, 1, 1, 0, 0); tick();
    apply(0, 1, 0, 0, 0, 3, 1, 0, 0, 0); tick();
    apply(1, 1, 3, 2, 1, 0, 0, 0, 0, 1);
    cmp("t6.rst_fwd", {30'b0, fa0}, 0);
    tick();
    apply(0, 1, 1, 3, 1, 0, 0, 0, 0, 0);
    cmp("t6.post_fwd_a", {30'b0, fa0}, 0);
    cmp("t6.post_fwd_b", {30'b0, fb0}, 0);
    cmp("t6.post_cnt", {16'b0, cnt0}, 0);
    cmp("t6.post_cnt1", {29'b0, cnt1}, 0);
    tick();

    // Random phase: small register set so matches, shadowing and hazards are common.
    for (int i = 0; i < 600; i++) begin
      apply($urandom_range(0, 49) == 0,
            $urandom_range(0, 5) != 0,
            int'($urandom_range(0, 7)),
            int'($urandom_range(0, 7)),
            $urandom_range(0, 1) == 1,
            int'($urandom_range(0, 7)),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 9) == 0,
            $urandom_range(0, 7) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
